sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
Message-schedule sequencer for the SHA-256 core. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream. It then emits the schedule words W0..W(ROUNDS-1) one per handshake to the compression-round stage. W0..W15 pass through from the block; later words are expanded in place in a 16-entry circular buffer using the rotate/shift sigma functions.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 17..64.

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous reset, active-high
in_valid  input  1  in_word holds a valid message word
in_ready  output  1  block can accept a word (high only in LOAD)
in_word  input  32  message word; first word is W0
out_valid  output  1  out_word holds a valid schedule word
out_ready  input  1  downstream accepts out_word
out_word  output  32  schedule word W[out_index]
out_index  output  6  index t of the current word, 0..ROUNDS-1
out_last  output  1  high with out_valid when t = ROUNDS-1
busy  output  1  high whenever state is not LOAD or load count is non-zero

Behaviour:
- Reset (async assert, sync release): state=LOAD, load count=0, t=0, all 16 buffer entries=0, in_ready=1, out_valid=0, out_word=0, out_index=0, out_last=0, busy=0.
- LOAD state:
  - in_ready=1 and out_valid=0.
  - Each cycle with in_valid=1 writes buf[cnt]=in_word and increments cnt.
  - The handshake that accepts the 16th word (cnt=15) moves the block to EMIT on the next cycle, with t=0 and cnt=0.
  - in_valid low stalls the load indefinitely; partial state is held.
- EMIT state:
  - in_ready=0 and out_valid=1. out_index=t; out_last=(t==ROUNDS-1).
  - For t<16: out_word = buf[t].
  - For t>=16: out_word = s1(buf[(t-2)%16]) + buf[(t-7)%16] + s0(buf[(t-15)%16]) + buf[t%16], with the sum taken mod 2^32.
  - s0(x) = rotr7(x) ^ rotr18(x) ^ shr3(x).
  - s1(x) = rotr17(x) ^ rotr19(x) ^ shr10(x).
  - Rotates are bit permutations; shifts fill with zeros.
  - out_word is combinational from the buffer and t. It has no internal pipeline, so an accepted word is available in the same cycle out_valid rises.
  - On a handshake (out_valid & out_ready) with t>=16, buf[t%16] is overwritten with out_word. For t<16 the buffer is not written. t then increments.
  - Backpressure: while out_ready=0, t, the buffer, out_word, out_index and out_last hold stable.
  - The handshake with out_last=1 returns the block to LOAD next cycle: t=0, cnt=0, in_ready=1.
  - No bubble cycles are required between blocks. The buffer is not cleared between blocks; all 16 entries are overwritten by the next load.
- Throughput: 16 load cycles plus ROUNDS emit cycles per block under full valid/ready.
- in_valid in EMIT is ignored; no word is consumed.
- rst asserted mid-LOAD or mid-EMIT aborts the block immediately and all state returns to reset values. A partial block is discarded.
- out_index width is fixed at 6 bits regardless of ROUNDS.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> out_word t0=0x61626380, t15=0x00000018, t16=0x61626380, t17=0x000F0000; all 64 words match the golden software model; out_last only at t=63.
- All-zero block -> 64 words all 0x00000000; in_ready returns high the cycle after the t=63 handshake.
- Random block with out_ready toggled pseudo-randomly (about 50% duty) -> out_word and out_index stable while stalled; sequence identical to the no-stall run.
- in_valid gapped (one word every 3 cycles) during LOAD -> exactly 16 words accepted, EMIT starts only after the 16th; in_valid held high during EMIT consumes nothing.
- Two back-to-back blocks with continuous valid/ready -> second block's W0 is accepted in the cycle after out_last; both schedules are correct with no stale-buffer contamination.
- rst pulsed at t=30 of EMIT, then a fresh "abc" block -> outputs return to 0 asynchronously; the following schedule matches the "abc" golden values exactly.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads one 16-word block, then streams
// W0..W(ROUNDS-1), expanding later words in place in a 16-entry circular buffer.
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [5:0]  t_reg, t_next;
    logic [31:0] word_buf [16];

    logic        load_fire;
    logic        emit_fire;
    logic        expand;
    logic        expand_fire;
    logic        is_last;
    logic [3:0]  idx;
    logic [3:0]  idx_m2;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m15;
    logic [31:0] expanded;
    logic [31:0] wr_data;
    logic [15:0] wr_en;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Modulo-16 buffer offsets fall out of plain 4-bit wraparound.
    assign idx     = t_reg[3:0];
    assign idx_m2  = idx - 4'd2;
    assign idx_m7  = idx - 4'd7;
    assign idx_m15 = idx - 4'd15;

    assign expand   = (t_reg >= 6'd16);
    assign is_last  = (t_reg == LAST_T);
    assign expanded = sigma1(word_buf[idx_m2]) + word_buf[idx_m7]
                    + sigma0(word_buf[idx_m15]) + word_buf[idx];

    assign load_fire   = (state_reg == LOAD) && in_valid;
    assign emit_fire   = (state_reg == EMIT) && out_ready;
    assign expand_fire = emit_fire && expand;

    always_comb begin
        out_word = '0;
        if (state_reg == EMIT) begin
            out_word = expand ? expanded : word_buf[idx];
        end
    end

    assign out_index = t_reg;
    assign out_last  = (state_reg == EMIT) && is_last;
    assign busy      = (state_reg != LOAD) || (cnt_reg != 4'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        t_next     = t_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        state_next = EMIT;
                        t_next     = '0;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (is_last) begin
                        state_next = LOAD;
                        t_next     = '0;
                        cnt_next   = '0;
                    end else begin
                        t_next = t_reg + 6'd1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
                t_next     = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
            cnt_reg   <= '0;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            t_reg     <= t_next;
        end
    end

    // Loads and expansions never overlap, so one shared write port suffices.
    assign wr_data = load_fire ? in_word : expanded;

    for (genvar gi = 0; gi < 16; gi++) begin : g_wr_en
        assign wr_en[gi] = (load_fire && (cnt_reg == 4'(gi)))
                         || (expand_fire && (idx == 4'(gi)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                word_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_en[i]) begin
                    word_buf[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: stimulus queues golden schedule words,
// a negedge monitor pops and compares every accepted output word.
module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;

    sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  index;
        logic        last;
        logic        abc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          last_neg_cycle = -10;
    bit          stall_mode = 0;
    logic [31:0] blk [16];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Golden schedule from the textbook recurrence over a full 64-entry array.
    task automatic push_expected(input bit abc);
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
                 + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-16];
        end
        for (int t = 0; t < ROUNDS; t++) begin
            e.word  = w[t];
            e.index = 6'(t);
            e.last  = (t == ROUNDS - 1);
            e.abc   = abc;
            exp_q.push_back(e);
        end
    endtask

    task automatic load_block(input int gap, input bit hold_valid, output int acc0_cycle);
        acc0_cycle = -1;
        for (int i = 0; i < 16; i++) begin
            in_word  = blk[i];
            in_valid = 1'b1;
            for (int k = 0; k < 300 && !in_ready; k++) begin
                @(posedge clk); #1;
            end
            if (!in_ready) begin
                n_checks++; n_fail++;
                $display("FAIL load_wait: in_ready=%0b required=1 for word %0d", in_ready, i);
            end
            @(posedge clk); #1;
            if (i == 0) acc0_cycle = cycle;
            if (gap > 0 && i < 15) begin
                in_valid = 1'b0;
                in_word  = 32'hBADC0FFE;
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
                if (i == 14) begin
                    chk("gap_no_emit_out_valid", 32'(out_valid), 32'd0);
                    chk("gap_in_ready", 32'(in_ready), 32'd1);
                    chk("gap_busy", 32'(busy), 32'd1);
                end
            end
        end
        in_valid = hold_valid;
        in_word  = 32'hDEADBEEF;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output acceptor
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor
    initial begin
        bit          after_last;
        bit          held;
        logic [31:0] held_word;
        logic [5:0]  held_idx;
        exp_t        e;
        after_last = 0;
        held = 0;
        held_word = '0;
        held_idx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
                after_last = 0;
                continue;
            end
            if (after_last) begin
                chk("in_ready_after_last", 32'(in_ready), 32'd1);
                chk("out_valid_after_last", 32'(out_valid), 32'd0);
                after_last = 0;
            end
            if (held && out_valid) begin
                chk("stall_word", out_word, held_word);
                chk("stall_index", 32'(out_index), 32'(held_idx));
            end
            held = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_word: index=%0d word=%08h, required no output", out_index, out_word);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", out_word, e.word);
                    chk("index", 32'(out_index), 32'(e.index));
                    chk("last", 32'(out_last), 32'(e.last));
                    if (e.abc) begin
                        case (e.index)
                            6'd0:  chk("abc_t0",  out_word, 32'h61626380);
                            6'd15: chk("abc_t15", out_word, 32'h00000018);
                            6'd16: chk("abc_t16", out_word, 32'h61626380);
                            6'd17: chk("abc_t17", out_word, 32'h000F0000);
                            6'd18: chk("abc_t18", out_word, 32'h7DA86405);
                            default: ;
                        endcase
                    end
                end
                if (out_last) begin
                    after_last = 1;
                    last_neg_cycle = cycle;
                end
            end else if (out_valid) begin
                held = 1;
                held_word = out_word;
                held_idx = out_index;
            end
        end
    end

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    // Stimulus
    initial begin
        int acc0;
        int found;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("test: abc block, continuous ready");
        set_abc();
        push_expected(1);
        load_block(0, 0, acc0);
        drain();

        $display("test: all-zero block");
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        push_expected(0);
        load_block(0, 0, acc0);
        drain();

        $display("test: random block with random backpressure");
        stall_mode = 1;
        set_random();
        push_expected(0);
        load_block(0, 0, acc0);
        drain();
        stall_mode = 0;

        $display("test: gapped load, in_valid held during emit");
        set_random();
        push_expected(0);
        load_block(2, 1, acc0);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_last) found = 1;
        end
        in_valid = 1'b0;
        if (found == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_out_last: not seen, required within 300 cycles");
        end
        drain();
        chk("hold_valid_busy", 32'(busy), 32'd0);
        chk("hold_valid_in_ready", 32'(in_ready), 32'd1);

        $display("test: back-to-back blocks");
        set_random();
        push_expected(0);
        load_block(0, 0, acc0);
        set_random();
        push_expected(0);
        load_block(0, 0, acc0);
        chk("b2b_w0_accept_cycle", 32'(acc0), 32'(last_neg_cycle + 2));
        drain();

        $display("test: reset at t=30, then abc block");
        set_abc();
        push_expected(1);
        load_block(0, 0, acc0);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (out_valid && out_index == 6'd30) found = 1;
        end
        if (found == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_t30: not seen, required within 300 cycles");
        end
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_word", out_word, 32'd0);
        chk("midrst_out_index", 32'(out_index), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        set_abc();
        push_expected(1);
        load_block(0, 0, acc0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
